// File: rtl/snake_pkg.sv
// snake_pkg: shared direction/state codes and playfield constants for the snake game.
package snake_pkg;
   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;
   typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_OVER} state_e;
   localparam int GRID_W = 32;
   localparam int GRID_H = 24;
   localparam int START_X = 16;
   localparam int START_Y = 12;
   // Up/down and left/right differ only in bit 0.
   function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction
endpackage

// File: rtl/snake_next_head.sv
// snake_next_head: effective direction, next head cell and wall detection.
module snake_next_head #(
   parameter int GRID_W = 32,
   parameter int GRID_H = 24
) (
   input  logic [4:0] head_x,
   input  logic [4:0] head_y,
   input  logic [1:0] cur_dir,
   input  logic [1:0] dir_in,
   output logic [1:0] eff_dir,
   output logic [4:0] next_x,
   output logic [4:0] next_y,
   output logic       wall
);
   import snake_pkg::*;
   logic [5:0] nx, ny;
   // A step below zero wraps to 63, which the range check catches as a wall.
   always_comb begin
      eff_dir = is_reverse(dir_in, cur_dir) ? cur_dir : dir_in;
      nx = {1'b0, head_x} + (eff_dir == DIR_RIGHT ? 6'd1 : eff_dir == DIR_LEFT ? 6'h3f : 6'd0);
      ny = {1'b0, head_y} + (eff_dir == DIR_DOWN ? 6'd1 : eff_dir == DIR_UP ? 6'h3f : 6'd0);
      wall = (nx >= 6'(GRID_W)) || (ny >= 6'(GRID_H));
      next_x = nx[4:0];
      next_y = ny[4:0];
   end
endmodule

// File: rtl/snake_body.sv
// snake_body: snake segment storage, movement, growth, food consumption and collision detection.
module snake_body #(
   parameter int MAX_LEN = 16,
   parameter int INIT_LEN = 3,
   parameter int GRID_W = 32,
   parameter int GRID_H = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] game_state,
   input  logic       step,
   input  logic [1:0] dir_in,
   input  logic [4:0] food_x,
   input  logic [4:0] food_y,
   output logic       get_food,
   output logic       hit,
   output logic [4:0] head_x,
   output logic [4:0] head_y,
   output logic [4:0] length,
   output logic [1:0] cur_dir,
   input  logic [4:0] qry_x,
   input  logic [4:0] qry_y,
   output logic       qry_body
);
   import snake_pkg::*;
   localparam int LW = $clog2(MAX_LEN) + 1;
   logic [4:0] seg_x [MAX_LEN];
   logic [4:0] seg_y [MAX_LEN];
   logic [LW-1:0] len;
   logic [1:0] eff_dir;
   logic [4:0] nx, ny;
   logic wall, move, eat, grow, self_hit;
   snake_next_head #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_next (
      .head_x(seg_x[0]),
      .head_y(seg_y[0]),
      .cur_dir(cur_dir),
      .dir_in(dir_in),
      .eff_dir(eff_dir),
      .next_x(nx),
      .next_y(ny),
      .wall(wall)
   );
   assign head_x = seg_x[0];
   assign head_y = seg_y[0];
   assign length = 5'(len);
   // Without growth the tail cell is vacated this step, so it is excluded from the self check.
   always_comb begin
      move = (game_state == ST_PLAY) && step && !hit;
      eat = (nx == food_x) && (ny == food_y);
      grow = eat && (len < LW'(MAX_LEN));
      self_hit = 1'b0;
      qry_body = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         self_hit |= (seg_x[i] == nx) && (seg_y[i] == ny) && (LW'(i) + LW'(!grow) < len);
         qry_body |= (seg_x[i] == qry_x) && (seg_y[i] == qry_y) && (LW'(i) < len);
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= 5'(START_X - i);
            seg_y[i] <= 5'(START_Y);
         end
         len <= LW'(INIT_LEN);
         cur_dir <= DIR_RIGHT;
         get_food <= 1'b0;
         hit <= 1'b0;
      end else if (game_state == ST_IDLE) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= 5'(START_X - i);
            seg_y[i] <= 5'(START_Y);
         end
         len <= LW'(INIT_LEN);
         cur_dir <= DIR_RIGHT;
         get_food <= 1'b0;
         hit <= 1'b0;
      end else begin
         get_food <= 1'b0;
         if (move) begin
            cur_dir <= eff_dir;
            if (wall || self_hit) hit <= 1'b1;
            else begin
               for (int i = 1; i < MAX_LEN; i++) begin
                  seg_x[i] <= seg_x[i-1];
                  seg_y[i] <= seg_y[i-1];
               end
               seg_x[0] <= nx;
               seg_y[0] <= ny;
               if (grow) len <= len + LW'(1);
               get_food <= eat;
            end
         end
      end
   end
endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: vector table, directed corner sequences and random steps against a queue-based snake model.
module tb_snake_body;
   logic clk = 0, rst = 1;
   logic [1:0] game_state = 0, dir_in = 0;
   logic step = 0;
   logic [4:0] food_x = 0, food_y = 0, qry_x = 0, qry_y = 0;
   logic get_food, hit, qry_body;
   logic [4:0] head_x, head_y, length;
   logic [1:0] cur_dir;
   int total = 0, bad = 0;
   int sx[$], sy[$];
   int mdir, mhit, mgf;

   snake_body dut (
      .clk(clk), .rst(rst), .game_state(game_state), .step(step), .dir_in(dir_in),
      .food_x(food_x), .food_y(food_y), .get_food(get_food), .hit(hit),
      .head_x(head_x), .head_y(head_y), .length(length), .cur_dir(cur_dir),
      .qry_x(qry_x), .qry_y(qry_y), .qry_body(qry_body)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] gs;
      logic stp;
      logic [1:0] d;
      int fx, fy, hx, hy, len, gf, dir;
   } vec_t;
   vec_t tbl[9];

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      total++;
      if (act !== 32'(exp)) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic minit();
      sx = {16, 15, 14};
      sy = {12, 12, 12};
      mdir = 3;
      mhit = 0;
      mgf = 0;
   endtask

   task automatic model(input int gs, input int stp, input int d, input int fx, input int fy);
      int nx, ny, lim;
      bit eat, grow, self_c;
      mgf = 0;
      if (gs == 0) begin
         minit();
         return;
      end
      if (gs != 1 || stp == 0 || mhit != 0) return;
      if (!((d / 2 == mdir / 2) && d != mdir)) mdir = d;
      nx = sx[0] + (mdir == 3 ? 1 : 0) - (mdir == 2 ? 1 : 0);
      ny = sy[0] + (mdir == 1 ? 1 : 0) - (mdir == 0 ? 1 : 0);
      if (nx < 0 || nx >= 32 || ny < 0 || ny >= 24) begin
         mhit = 1;
         return;
      end
      eat = (nx == fx) && (ny == fy);
      grow = eat && sx.size() < 16;
      lim = grow ? sx.size() : sx.size() - 1;
      self_c = 0;
      for (int i = 0; i < lim; i++) if (sx[i] == nx && sy[i] == ny) self_c = 1;
      if (self_c) begin
         mhit = 1;
         return;
      end
      sx.push_front(nx);
      sy.push_front(ny);
      if (!grow) begin
         void'(sx.pop_back());
         void'(sy.pop_back());
      end
      mgf = eat ? 1 : 0;
   endtask

   task automatic compare_all();
      int qx, qy, occ, k;
      if ($urandom_range(0, 1) == 1) begin
         k = $urandom_range(0, sx.size() - 1);
         qx = sx[k];
         qy = sy[k];
      end else begin
         qx = $urandom_range(0, 31);
         qy = $urandom_range(0, 31);
      end
      qry_x = 5'(qx);
      qry_y = 5'(qy);
      #1;
      occ = 0;
      for (int i = 0; i < sx.size(); i++) if (sx[i] == qx && sy[i] == qy) occ = 1;
      chk("head_x", 32'(head_x), sx[0]);
      chk("head_y", 32'(head_y), sy[0]);
      chk("length", 32'(length), sx.size());
      chk("hit", 32'(hit), mhit);
      chk("cur_dir", 32'(cur_dir), mdir);
      chk("get_food", 32'(get_food), mgf);
      chk("qry_body", 32'(qry_body), occ);
   endtask

   task automatic run(input logic [1:0] gs, input logic stp, input logic [1:0] d, input int fx, input int fy);
      game_state = gs;
      step = stp;
      dir_in = d;
      food_x = 5'(fx);
      food_y = 5'(fy);
      @(posedge clk);
      model(int'(gs), int'(stp), int'(d), fx & 31, fy & 31);
      #1;
      compare_all();
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_hx"}, 32'(head_x), 16);
      chk({nm, "_hy"}, 32'(head_y), 12);
      chk({nm, "_len"}, 32'(length), 3);
      chk({nm, "_hit"}, 32'(hit), 0);
      chk({nm, "_gf"}, 32'(get_food), 0);
      chk({nm, "_dir"}, 32'(cur_dir), 3);
   endtask

   initial begin
      int fx, fy, d, r;
      tbl[0] = '{2'b01, 1'b0, 2'd3, 0, 0, 16, 12, 3, 0, 3};
      tbl[1] = '{2'b01, 1'b1, 2'd3, 0, 0, 17, 12, 3, 0, 3};
      tbl[2] = '{2'b01, 1'b1, 2'd3, 0, 0, 18, 12, 3, 0, 3};
      tbl[3] = '{2'b01, 1'b1, 2'd3, 0, 0, 19, 12, 3, 0, 3};
      tbl[4] = '{2'b01, 1'b1, 2'd3, 0, 0, 20, 12, 3, 0, 3};
      tbl[5] = '{2'b01, 1'b1, 2'd3, 21, 12, 21, 12, 4, 1, 3};
      tbl[6] = '{2'b01, 1'b0, 2'd3, 0, 0, 21, 12, 4, 0, 3};
      tbl[7] = '{2'b01, 1'b1, 2'd2, 0, 0, 22, 12, 4, 0, 3};
      tbl[8] = '{2'b01, 1'b1, 2'd1, 0, 0, 22, 13, 4, 0, 1};
      #12;
      check_reset_vals("reset");
      rst = 0;
      minit();

      for (int i = 0; i < 9; i++) begin
         run(tbl[i].gs, tbl[i].stp, tbl[i].d, tbl[i].fx, tbl[i].fy);
         chk($sformatf("vec%0d_hx", i), 32'(head_x), tbl[i].hx);
         chk($sformatf("vec%0d_hy", i), 32'(head_y), tbl[i].hy);
         chk($sformatf("vec%0d_len", i), 32'(length), tbl[i].len);
         chk($sformatf("vec%0d_gf", i), 32'(get_food), tbl[i].gf);
         chk($sformatf("vec%0d_dir", i), 32'(cur_dir), tbl[i].dir);
         chk($sformatf("vec%0d_hit", i), 32'(hit), 0);
      end

      // growth keeps the old tail, pulse lasts one cycle
      run(0, 0, 3, 0, 0);
      run(1, 1, 3, 17, 12);
      chk("grow_len", 32'(length), 4);
      chk("grow_gf", 32'(get_food), 1);
      qry_x = 14;
      qry_y = 12;
      #1;
      chk("grow_tail", 32'(qry_body), 1);
      run(1, 0, 3, 17, 12);
      chk("grow_gf_drop", 32'(get_food), 0);

      // wall at the right edge, then idle re-initialisation
      run(0, 0, 3, 0, 0);
      for (int i = 0; i < 7; i++) run(1, 1, 0, 0, 0);
      for (int i = 0; i < 15; i++) run(1, 1, 3, 0, 0);
      chk("edge_hx", 32'(head_x), 31);
      chk("edge_hy", 32'(head_y), 5);
      run(1, 1, 3, 0, 0);
      chk("wall_hit", 32'(hit), 1);
      chk("wall_hx", 32'(head_x), 31);
      run(1, 1, 1, 0, 0);
      run(1, 1, 0, 0, 0);
      chk("wall_frozen_hy", 32'(head_y), 5);
      run(0, 0, 3, 0, 0);
      check_reset_vals("idle");

      // self collision at length 5
      run(1, 1, 3, 17, 12);
      run(1, 1, 3, 18, 12);
      chk("self_len5", 32'(length), 5);
      run(1, 1, 1, 0, 0);
      run(1, 1, 2, 0, 0);
      run(1, 1, 0, 0, 0);
      chk("self_hit", 32'(hit), 1);
      chk("self_hx", 32'(head_x), 17);
      chk("self_hy", 32'(head_y), 13);

      // moving into the cell the tail vacates is legal
      run(0, 0, 3, 0, 0);
      run(1, 1, 3, 17, 12);
      run(1, 1, 1, 0, 0);
      run(1, 1, 2, 0, 0);
      run(1, 1, 0, 0, 0);
      chk("tail_nohit", 32'(hit), 0);
      chk("tail_hx", 32'(head_x), 16);
      chk("tail_hy", 32'(head_y), 12);

      // async reset during the get_food cycle
      run(0, 0, 3, 0, 0);
      run(1, 1, 3, 17, 12);
      chk("pre_rst_gf", 32'(get_food), 1);
      rst = 1;
      #1;
      check_reset_vals("async_rst");
      minit();
      #1 rst = 0;

      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 99);
         d = $urandom_range(0, 3);
         if (r < 3 || (mhit != 0 && r < 15)) game_state = 0;
         else if (r < 7) game_state = 2;
         else game_state = 1;
         if ($urandom_range(0, 9) < 4) begin
            fx = sx[0] + (d == 3 ? 1 : 0) - (d == 2 ? 1 : 0);
            fy = sy[0] + (d == 1 ? 1 : 0) - (d == 0 ? 1 : 0);
         end else begin
            fx = $urandom_range(0, 31);
            fy = $urandom_range(0, 31);
         end
         run(game_state, ($urandom_range(0, 3) != 0), 2'(d), fx & 31, fy & 31);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
